// File: rtl/fp_mul_pkg.sv
// Shared types and helpers for the pipelined float multiplier.
package fp_mul_pkg;
  typedef enum logic [1:0] {ZERO, NORM, INF, NAN} fp_class_t;

  localparam int FLG_INV = 3;
  localparam int FLG_OVF = 2;
  localparam int FLG_UNF = 1;
  localparam int FLG_INX = 0;

  localparam logic [31:0] QNAN_SP = 32'h7FC0_0000;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic int fp_width(input int exp_w, input int man_w);
    return 1 + exp_w + man_w;
  endfunction
endpackage

// File: rtl/fp_mul_round.sv
// S3 normalise/round/pack. Rounding mode: FP_MUL_RNE_EN defined -> round to nearest even,
// otherwise truncation toward zero.
module fp_mul_round
  import fp_mul_pkg::*;
#(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  localparam int W     = fp_width(EXP_W, MAN_W),
  localparam int EW2   = EXP_W + 2,
  localparam int PW    = 2 * (MAN_W + 1)
) (
  input  logic                  sign,
  input  logic                  sp_hit,
  input  logic [W-1:0]          sp_res,
  input  logic [3:0]            sp_flg,
  input  logic signed [EW2-1:0] esum,
  input  logic [PW-1:0]         prod,
  output logic [W-1:0]          res,
  output logic [3:0]            flg
);
  localparam logic signed [EW2-1:0] E_MAX = EW2'((1 << EXP_W) - 1);

  logic                  norm, guard, sticky, rnd_up, inx;
  logic [PW-1:0]         shifted;
  logic [MAN_W:0]        man_full;
  logic [MAN_W+1:0]      man_r;
  logic [MAN_W-1:0]      frac;
  logic signed [EW2-1:0] e, e_fin;

  always_comb begin
    norm     = prod[PW-1];
    shifted  = norm ? prod : {prod[PW-2:0], 1'b0};
    man_full = shifted[PW-1 -: MAN_W+1];
    guard    = shifted[MAN_W];
    sticky   = |shifted[MAN_W-1:0];
    inx      = guard | sticky;
    e        = esum + EW2'(norm);
`ifdef FP_MUL_RNE_EN
    rnd_up   = guard & (sticky | man_full[0]);
`else
    rnd_up   = 1'b0;
`endif
    man_r    = {1'b0, man_full} + (MAN_W+2)'(rnd_up);
    // rounding carry into the hidden bit: shift back and bump the exponent
    frac     = man_r[MAN_W+1] ? man_r[MAN_W:1] : man_r[MAN_W-1:0];
    e_fin    = e + EW2'(man_r[MAN_W+1]);

    res = '0;
    flg = '0;
    if (sp_hit) begin
      res = sp_res;
      flg = sp_flg;
    end else if (e <= 0) begin
      res          = {sign, {(W-1){1'b0}}};
      flg[FLG_UNF] = 1'b1;
      flg[FLG_INX] = 1'b1;
    end else if (e_fin >= E_MAX) begin
      res          = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flg[FLG_OVF] = 1'b1;
      flg[FLG_INX] = 1'b1;
    end else begin
      res          = {sign, e_fin[EXP_W-1:0], frac};
      flg[FLG_INX] = inx;
    end
  end
endmodule

// File: rtl/fp_mul_pipe.sv
// 3-stage float multiplier with valid/ready and run-time mantissa masking.
// Rounding selected by FP_MUL_RNE_EN (see fp_mul_round).
module fp_mul_pipe
  import fp_mul_pkg::*;
#(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  localparam int W     = fp_width(EXP_W, MAN_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [MAN_W-1:0] approx_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     result,
  output logic [3:0]       flags
);
  localparam int STAGES = 3;
  localparam int EW2    = EXP_W + 2;
  localparam int PW     = 2 * (MAN_W + 1);
  localparam int BIAS   = fp_bias(EXP_W);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef struct packed {
    logic           sign;
    logic           sp_hit;
    logic [W-1:0]   sp_res;
    logic [3:0]     sp_flg;
    logic [EW2-1:0] esum;
  } meta_t;

  function automatic fp_class_t classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
    if (e == '0)    return ZERO;
    else if (&e)    return (f != '0) ? NAN : INF;
    else            return NORM;
  endfunction

  logic               en;
  logic [STAGES:1]    vld_pipe;
  fp_class_t          ca, cb;
  meta_t              s1_in, s1_meta, s2_meta;
  logic [MAN_W:0]     s1_ma, s1_mb;
  logic [PW-1:0]      s2_prod;
  logic [W-1:0]       rnd_res;
  logic [3:0]         rnd_flg;

  assign en        = !out_valid | out_ready;
  assign in_ready  = en;
  assign out_valid = vld_pipe[STAGES];

  // S1: classify on the unmasked fields, so masking never turns a NaN into Inf
  always_comb begin
    ca            = classify(a[W-2 -: EXP_W], a[MAN_W-1:0]);
    cb            = classify(b[W-2 -: EXP_W], b[MAN_W-1:0]);
    s1_in         = '0;
    s1_in.sign    = a[W-1] ^ b[W-1];
    s1_in.esum    = EW2'(a[W-2 -: EXP_W]) + EW2'(b[W-2 -: EXP_W]) - EW2'(BIAS);
    s1_in.sp_hit  = 1'b1;
    if (ca == NAN || cb == NAN || (ca == INF && cb == ZERO) || (ca == ZERO && cb == INF)) begin
      s1_in.sp_res          = QNAN;
      s1_in.sp_flg[FLG_INV] = 1'b1;
    end else if (ca == INF || cb == INF) begin
      s1_in.sp_res = {s1_in.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (ca == ZERO || cb == ZERO) begin
      s1_in.sp_res = {s1_in.sign, {(W-1){1'b0}}};
    end else begin
      s1_in.sp_hit = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1_meta  <= '0;
      s1_ma    <= '0;
      s1_mb    <= '0;
      s2_meta  <= '0;
      s2_prod  <= '0;
      result   <= '0;
      flags    <= '0;
    end else if (en) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
      s1_meta  <= s1_in;
      s1_ma    <= {1'b1, a[MAN_W-1:0] & ~approx_mask};
      s1_mb    <= {1'b1, b[MAN_W-1:0] & ~approx_mask};
      s2_meta  <= s1_meta;
      s2_prod  <= PW'(s1_ma) * PW'(s1_mb);
      if (vld_pipe[STAGES-1]) begin
        result <= rnd_res;
        flags  <= rnd_flg;
      end
    end
  end

  fp_mul_round #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round (
    .sign   (s2_meta.sign),
    .sp_hit (s2_meta.sp_hit),
    .sp_res (s2_meta.sp_res),
    .sp_flg (s2_meta.sp_flg),
    .esum   (s2_meta.esum),
    .prod   (s2_prod),
    .res    (rnd_res),
    .flg    (rnd_flg)
  );
endmodule
